// File: rtl/bo_datapath_if.sv
// rtl/bo_datapath_if.sv - control word and register/status bus between BC controller and BO datapath
interface bo_datapath_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] X_in;
   logic             LX;
   logic             LS;
   logic             LH;
   logic             H;
   logic [1:0]       M0;
   logic [1:0]       M1;
   logic [1:0]       M2;
   logic [WIDTH-1:0] S_out;
   logic [WIDTH-1:0] X_out;
   logic [WIDTH-1:0] H_out;
   logic             zero;
   logic             ovf;

   modport master (
      output X_in, LX, LS, LH, H, M0, M1, M2,
      input  S_out, X_out, H_out, zero, ovf
   );

   modport slave (
      input  X_in, LX, LS, LH, H, M0, M1, M2,
      output S_out, X_out, H_out, zero, ovf
   );
endinterface

// File: rtl/bo_datapath.sv
// rtl/bo_datapath.sv - three-register datapath with one shared add/multiply ALU
module bo_datapath #(
   parameter int WIDTH   = 8,
   parameter int CONST_K = 1
) (
   input  logic          clk,
   input  logic          reset,
   bo_datapath_if.slave  bus
);
   logic [WIDTH-1:0]   rx_q, rx_d;
   logic [WIDTH-1:0]   rs_q, rs_d;
   logic [WIDTH-1:0]   rh_q, rh_d;
   logic               zero_q, zero_d;
   logic               ovf_q, ovf_d;

   logic [WIDTH-1:0]   op_a, op_b;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_ovf;
   logic [WIDTH-1:0]   rs_src;
   logic               rs_from_alu;

   // Operand muxes: A picks a register or the constant, B picks a register, X_in or zero
   always_comb begin
      op_a = WIDTH'(CONST_K);
      case (bus.M0)
         2'd0:    op_a = rx_q;
         2'd1:    op_a = rs_q;
         2'd2:    op_a = rh_q;
         default: op_a = WIDTH'(CONST_K);
      endcase
      op_b = '0;
      case (bus.M1)
         2'd0:    op_b = rs_q;
         2'd1:    op_b = bus.X_in;
         2'd2:    op_b = rh_q;
         default: op_b = '0;
      endcase
   end

   // Shared ALU: result truncated to WIDTH, overflow flags any lost high bits
   always_comb begin
      sum  = {1'b0, op_a} + {1'b0, op_b};
      prod = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
      if (bus.H) begin
         alu_res = sum[WIDTH-1:0];
         alu_ovf = sum[WIDTH];
      end else begin
         alu_res = prod[WIDTH-1:0];
         alu_ovf = |prod[2*WIDTH-1:WIDTH];
      end
   end

   // Next-state: every load sees pre-edge register values; status tracks ALU-sourced loads
   always_comb begin
      rs_src = alu_res;
      case (bus.M2)
         2'd0:    rs_src = alu_res;
         2'd1:    rs_src = op_a;
         2'd2:    rs_src = alu_res >> 1;
         default: rs_src = rh_q;
      endcase
      rs_from_alu = bus.LS && (bus.M2 == 2'd0 || bus.M2 == 2'd2);

      rx_d   = bus.LX ? op_b   : rx_q;
      rs_d   = bus.LS ? rs_src : rs_q;
      rh_d   = bus.LH ? alu_res : rh_q;

      zero_d = zero_q;
      if (rs_from_alu) begin
         zero_d = (rs_src == '0);
      end else if (bus.LH) begin
         zero_d = (alu_res == '0);
      end

      ovf_d = ovf_q | (alu_ovf & (bus.LH | rs_from_alu));
   end

   // State register; reset overrides any load in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_q   <= '0;
         rs_q   <= '0;
         rh_q   <= '0;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         rx_q   <= rx_d;
         rs_q   <= rs_d;
         rh_q   <= rh_d;
         zero_q <= zero_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.S_out = rs_q;
   assign bus.X_out = rx_q;
   assign bus.H_out = rh_q;
   assign bus.zero  = zero_q;
   assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_bo_datapath.sv
// tb/tb_bo_datapath.sv - directed and randomized self-checking bench for bo_datapath
module tb_bo_datapath;
   localparam int WIDTH   = 8;
   localparam int CONST_K = 1;
   localparam int MODV    = 1 << WIDTH;

   logic clk = 1'b0;
   logic reset;

   bo_datapath_if #(.WIDTH(WIDTH)) bus ();

   bo_datapath #(.WIDTH(WIDTH), .CONST_K(CONST_K)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // reference state, held as plain integers
   int m_rx, m_rs, m_rh;
   bit m_zero, m_ovf;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Advance the model by one control word, clock the DUT, compare every output
   task automatic step(input bit rst, input bit lx, input bit ls, input bit lh, input bit h,
                       input int m0, input int m1, input int m2, input int x);
      int a, b, full, res, rsval;
      bit of, alu_load_rs;
      reset    = rst;
      bus.LX   = lx;
      bus.LS   = ls;
      bus.LH   = lh;
      bus.H    = h;
      bus.M0   = 2'(m0);
      bus.M1   = 2'(m1);
      bus.M2   = 2'(m2);
      bus.X_in = WIDTH'(x);

      a = (m0 == 0) ? m_rx : (m0 == 1) ? m_rs : (m0 == 2) ? m_rh : CONST_K;
      b = (m1 == 0) ? m_rs : (m1 == 1) ? x    : (m1 == 2) ? m_rh : 0;
      full  = h ? a + b : a * b;
      res   = full % MODV;
      of    = (full >= MODV);
      rsval = (m2 == 0) ? res : (m2 == 1) ? a : (m2 == 2) ? res / 2 : m_rh;
      alu_load_rs = ls && (m2 == 0 || m2 == 2);

      if (rst) begin
         m_rx = 0; m_rs = 0; m_rh = 0; m_zero = 0; m_ovf = 0;
      end else begin
         if (alu_load_rs)  m_zero = (rsval == 0);
         else if (lh)      m_zero = (res == 0);
         if (of && (lh || alu_load_rs)) m_ovf = 1;
         if (lx) m_rx = b;
         if (ls) m_rs = rsval;
         if (lh) m_rh = res;
      end

      @(posedge clk);
      #1;
      check("rx",   int'(bus.X_out), m_rx);
      check("rs",   int'(bus.S_out), m_rs);
      check("rh",   int'(bus.H_out), m_rh);
      check("zero", int'(bus.zero),  int'(m_zero));
      check("ovf",  int'(bus.ovf),   int'(m_ovf));
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1;
      bus.LX = 0; bus.LS = 0; bus.LH = 0; bus.H = 0;
      bus.M0 = 0; bus.M1 = 0; bus.M2 = 0; bus.X_in = 0;
      m_rx = 0; m_rs = 0; m_rh = 0; m_zero = 0; m_ovf = 0;
      #2;

      // 1: reset beats simultaneous loads
      step(1, 1, 1, 1, 1, 0, 1, 0, 8'h55);
      check("t1_rx", int'(bus.X_out), 0);
      check("t1_rs", int'(bus.S_out), 0);
      check("t1_rh", int'(bus.H_out), 0);
      check("t1_flags", int'({bus.zero, bus.ovf}), 0);

      // 2: load X, then RH = RX + X_in
      step(0, 1, 0, 0, 0, 0, 1, 0, 5);
      check("t2_rx", int'(bus.X_out), 5);
      step(0, 0, 0, 1, 1, 0, 1, 0, 3);
      check("t2_rh", int'(bus.H_out), 8);
      check("t2_zero", int'(bus.zero), 0);

      // 4: RS=2 while RH=8, then swap-like load without forwarding
      step(0, 1, 0, 0, 0, 0, 1, 0, 2);
      step(0, 0, 1, 0, 0, 0, 0, 1, 0);
      check("t4_rs_setup", int'(bus.S_out), 2);
      step(0, 0, 1, 1, 1, 1, 2, 3, 0);
      check("t4_rs", int'(bus.S_out), 8);
      check("t4_rh", int'(bus.H_out), 10);

      // 3: 16*16 wraps to 0, zero and sticky ovf
      step(0, 1, 0, 0, 0, 0, 1, 0, 16);
      step(0, 0, 1, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0, 0);
      check("t3_rh", int'(bus.H_out), 0);
      check("t3_zero", int'(bus.zero), 1);
      check("t3_ovf", int'(bus.ovf), 1);
      for (int i = 0; i < 10; i++) idle();
      check("t3_ovf_sticky", int'(bus.ovf), 1);

      // 5: add carry then logical shift into RS
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("t5_ovf_cleared", int'(bus.ovf), 0);
      step(0, 1, 0, 0, 0, 0, 1, 0, 200);
      step(0, 0, 1, 0, 1, 0, 1, 2, 100);
      check("t5_rs", int'(bus.S_out), 22);
      check("t5_ovf", int'(bus.ovf), 1);

      // 6: controller sequence A..F computing X*X + X, with hold in F
      step(1, 0, 0, 0, 0, 0, 0, 0, 3);   // A
      step(0, 1, 0, 0, 0, 0, 1, 0, 3);   // B: RX = X
      step(0, 0, 1, 0, 0, 0, 0, 1, 3);   // C: RS = RX
      step(0, 0, 0, 1, 0, 0, 0, 0, 3);   // D: RH = RX*RS
      step(0, 0, 1, 0, 1, 2, 1, 0, 3);   // E: RS = RH + X
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 3); // F
      check("t6_rx", int'(bus.X_out), 3);
      check("t6_rh", int'(bus.H_out), 9);
      check("t6_rs", int'(bus.S_out), 12);

      // randomized control words with occasional reset
      for (int i = 0; i < 400; i++) begin
         bit r, lx, ls, lh, h;
         int m0, m1, m2;
         r  = ($urandom_range(0, 29) == 0);
         lx = 1'($urandom);
         ls = 1'($urandom);
         lh = 1'($urandom);
         h  = 1'($urandom);
         m0 = $urandom_range(0, 3);
         m1 = $urandom_range(0, 3);
         m2 = $urandom_range(0, 3);
         if (lh && ls && m2 == 2) m2 = 0;
         step(r, lx, ls, lh, h, m0, m1, m2, $urandom_range(0, MODV - 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
